// File: rtl/ram_parity_scrub.sv
// ram_parity_scrub: single-port synchronous RAM with one parity bit per word,
// a zero-fill init sequencer, registered reads and a saturating error log.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req, we           access request (qualified by ready), 1 = write
//   addr, wdata       access address and write data
//   inj_err           on a write, store the inverted parity bit
//   err_clr           clear err_cnt and err_addr
//   ready             init finished, requests are accepted
//   rvalid            one-cycle pulse qualifying rdata and par_err
//   rdata, par_err    registered read data and its parity check result
//   err_cnt, err_addr saturating error count, address of first logged error
module ram_parity_scrub #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int PARITY_ODD = 0,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  inj_err,
    input  logic                  err_clr,
    output logic                  ready,
    output logic                  rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  par_err,
    output logic [CNT_WIDTH-1:0]  err_cnt,
    output logic [ADDR_WIDTH-1:0] err_addr
);
    localparam int   DEPTH = 2 ** ADDR_WIDTH;
    localparam logic PO    = (PARITY_ODD != 0);

    typedef enum logic {INIT, IDLE} state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   init_ptr;
    logic [DATA_WIDTH:0]     mem [DEPTH];
    logic [DATA_WIDTH:0]     rd_word;
    logic                    rd, wr, err;

    assign ready   = (state == IDLE);
    assign rd      = ready & req & ~we;
    assign wr      = ready & req & we;
    assign rd_word = mem[addr];
    // A word {par, data} is consistent when its full XOR equals the parity sense.
    assign err     = rd & ((^rd_word) != PO);

    always_comb begin
        state_nxt = (state == INIT && &init_ptr) ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT;
            init_ptr <= '0;
        end else begin
            state    <= state_nxt;
            init_ptr <= (state == INIT) ? init_ptr + ADDR_WIDTH'(1) : init_ptr;
        end
    end

    // The array has no reset; the INIT walk makes every word parity-clean.
    always_ff @(posedge clk) begin
        if (state == INIT)
            mem[init_ptr] <= {PO, {DATA_WIDTH{1'b0}}};
        else if (wr)
            mem[addr] <= {(^wdata) ^ PO ^ inj_err, wdata};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid   <= 1'b0;
            rdata    <= '0;
            par_err  <= 1'b0;
            err_cnt  <= '0;
            err_addr <= '0;
        end else begin
            rvalid  <= rd;
            par_err <= err;
            if (rd)
                rdata <= rd_word[DATA_WIDTH-1:0];
            // A logged error takes priority over a coincident clear and restarts the log.
            if (err) begin
                err_cnt  <= err_clr ? CNT_WIDTH'(1) : (&err_cnt ? err_cnt : err_cnt + CNT_WIDTH'(1));
                err_addr <= (err_clr || err_cnt == '0) ? addr : err_addr;
            end else if (err_clr) begin
                err_cnt  <= '0;
                err_addr <= '0;
            end
        end
    end
endmodule
